fu_div: RTL and testbench
=========================

FU_DIV -- requirements
Module: fu_div

Interface
REQ-001 Parameter: early_out, 1, when 1 divide-by-zero and signed-overflow cases resolve without iteration; when 0 they iterate like normal operations and give identical results.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 flush  input  1  kill any in-flight or completed-but-unclaimed operation.
REQ-005 req_opid  input  16  operation id; bit 15 is the request-valid flag.
REQ-006 req_funct  input  3  bit0 unsigned, bit1 remainder (else quotient), bit2 word (32-bit) variant.
REQ-007 req_a, req_b  input  64 each  dividend, divisor.
REQ-008 req_ready  output  1  unit can accept a request this cycle.
REQ-009 resp_opid  output  16  response id; bit 15 is the response-valid flag read by the execute-stage arbiter.
REQ-010 resp_data  output  64  result.
REQ-011 resp_claim  input  1  arbiter consumes the presented response this cycle.

Function
REQ-012 FSM states IDLE, BUSY, DONE; req_ready = 1 only in IDLE.
REQ-013 Acceptance: cycle T with req_opid[15] & req_ready; opid, funct, operands latched at T; unaccepted requests ignored.
REQ-014 IDLE -> BUSY at T+1 with iteration count n = 32 (word) or 64 (full) for normal cases.
REQ-015 BUSY: one restoring radix-2 iteration per cycle on operand magnitudes; after n iterations -> DONE, so resp_opid[15] first asserts at T+1+n.
REQ-016 Signed ops: divide magnitudes; quotient negated when operand signs differ; remainder takes dividend sign.
REQ-017 Word ops: operands truncated to bits 31:0, sign- or zero-extended per bit0; 32-bit result sign-extended to 64 bits for all four word variants.
REQ-018 Divisor zero: quotient all ones (in operand width), remainder = dividend (in operand width).
REQ-019 Signed overflow (most-negative / -1, per width): quotient = dividend, remainder = 0.
REQ-020 early_out=1: REQ-018/019 cases go IDLE -> DONE, response valid at T+1.
REQ-021 DONE: resp_opid = latched opid with bit 15 = 1, resp_data stable, held indefinitely until claim.
REQ-022 resp_claim in DONE -> IDLE next cycle, resp_opid[15] = 0; no new acceptance in the claim cycle.
REQ-023 resp_claim outside DONE ignored.
REQ-024 flush in any state -> IDLE next cycle, resp_opid[15] = 0; flush overrides a simultaneous claim and a simultaneous request (request not accepted).
REQ-025 resp_opid[15] = 0 whenever state is not DONE; resp_data undefined-but-stable then (drive 0).

Reset
REQ-026 rst -> IDLE, resp_opid = 0, resp_data = 0, req_ready = 1 next cycle; mid-operation reset discards the operation with no response.
REQ-027 rst has priority over flush, claim, and request.

Verification
REQ-028 DIV 100 / 7 accepted at T, claim held high -> resp_data = 14 valid at T+65, IDLE at T+66.
REQ-029 REM -7 / 2 -> resp_data = -1 (0xFFFF_FFFF_FFFF_FFFF); REMU 7 / 2 -> 1; both valid at T+65.
REQ-030 DIVU 5 / 0, early_out=1 -> resp_data = 0xFFFF_FFFF_FFFF_FFFF at T+1; REM 5 / 0 -> 5; early_out=0 -> same values at T+65.
REQ-031 DIVW 0x8000_0000 / 0xFFFF_FFFF -> resp_data = 0xFFFF_FFFF_8000_0000; DIVUW 0xFFFF_FFFE / 1 -> 0xFFFF_FFFF_FFFF_FFFE; normal word results at T+33.
REQ-032 Back-pressure: claim low 10 cycles after DONE -> resp_opid, resp_data unchanged, req_ready = 0 throughout; claim pulse -> valid drops next cycle, req_ready = 1.
REQ-033 Flush at T+20 during BUSY, and separately flush with simultaneous claim in DONE -> IDLE next cycle, no response ever presented for that opid; rst at T+20 -> same.

Source files
------------

// File: rtl/fu_div.sv
// rtl/fu_div.sv - iterative restoring radix-2 integer divide/remainder unit
// One iteration per cycle on operand magnitudes; signs are reapplied when the result is presented.
module fu_div #(
  parameter bit early_out = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic [15:0] req_opid,
  input  logic [2:0]  req_funct,
  input  logic [63:0] req_a,
  input  logic [63:0] req_b,
  output logic        req_ready,
  output logic [15:0] resp_opid,
  output logic [63:0] resp_data,
  input  logic        resp_claim
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e      state_q, state_d;
  logic [14:0] opid_q, opid_d;
  logic        word_q, word_d;
  logic        rsel_q, rsel_d;
  logic        qneg_q, qneg_d;
  logic        rneg_q, rneg_d;
  logic [63:0] prem_q, prem_d;
  logic [63:0] dq_q, dq_d;
  logic [63:0] dvs_q, dvs_d;
  logic [6:0]  cnt_q, cnt_d;

  logic [63:0] a_ext, b_ext, a_mag, b_mag;
  logic        a_neg, b_neg, b_zero, ovf;
  logic [64:0] shifted, diff;
  logic        qbit;
  logic [63:0] quo, rem, sel;

  assign a_ext  = req_funct[2] ? (req_funct[0] ? {32'b0, req_a[31:0]} : {{32{req_a[31]}}, req_a[31:0]}) : req_a;
  assign b_ext  = req_funct[2] ? (req_funct[0] ? {32'b0, req_b[31:0]} : {{32{req_b[31]}}, req_b[31:0]}) : req_b;
  assign a_neg  = ~req_funct[0] & a_ext[63];
  assign b_neg  = ~req_funct[0] & b_ext[63];
  assign a_mag  = a_neg ? (~a_ext + 64'd1) : a_ext;
  assign b_mag  = b_neg ? (~b_ext + 64'd1) : b_ext;
  assign b_zero = (b_ext == 64'd0);
  assign ovf    = ~req_funct[0] & (b_ext == {64{1'b1}}) &
                  (a_ext == (req_funct[2] ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000));

  // Partial remainder stays below the divisor, so a non-negative difference always fits 64 bits
  // and bit 64 of the difference is a clean borrow flag.
  assign shifted = {prem_q, dq_q[63]};
  assign diff    = shifted - {1'b0, dvs_q};
  assign qbit    = ~diff[64];

  assign quo = qneg_q ? (~dq_q + 64'd1) : dq_q;
  assign rem = rneg_q ? (~prem_q + 64'd1) : prem_q;
  assign sel = rsel_q ? rem : quo;

  assign resp_opid = (state_q == DONE) ? {1'b1, opid_q} : 16'h0000;
  assign resp_data = (state_q == DONE) ? (word_q ? {{32{sel[31]}}, sel[31:0]} : sel) : 64'd0;

  always_comb begin
    state_d   = state_q;
    opid_d    = opid_q;
    word_d    = word_q;
    rsel_d    = rsel_q;
    qneg_d    = qneg_q;
    rneg_d    = rneg_q;
    prem_d    = prem_q;
    dq_d      = dq_q;
    dvs_d     = dvs_q;
    cnt_d     = cnt_q;
    req_ready = (state_q == IDLE);
    case (state_q)
      IDLE: begin
        if (req_opid[15]) begin
          opid_d = req_opid[14:0];
          word_d = req_funct[2];
          rsel_d = req_funct[1];
          // A zero divisor yields an all-ones quotient regardless of dividend sign.
          qneg_d = (a_neg ^ b_neg) & ~b_zero;
          rneg_d = a_neg;
          dvs_d  = b_mag;
          cnt_d  = req_funct[2] ? 7'd32 : 7'd64;
          if (early_out && (b_zero || ovf)) begin
            prem_d  = b_zero ? a_mag : 64'd0;
            dq_d    = b_zero ? (req_funct[2] ? 64'h0000_0000_FFFF_FFFF : {64{1'b1}}) : a_mag;
            state_d = DONE;
          end else begin
            prem_d  = 64'd0;
            dq_d    = req_funct[2] ? {a_mag[31:0], 32'd0} : a_mag;
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        prem_d = qbit ? diff[63:0] : shifted[63:0];
        dq_d   = {dq_q[62:0], qbit};
        cnt_d  = cnt_q - 7'd1;
        if (cnt_q == 7'd1) state_d = DONE;
      end
      DONE: begin
        if (resp_claim) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      opid_q  <= 15'd0;
      word_q  <= 1'b0;
      rsel_q  <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      prem_q  <= 64'd0;
      dq_q    <= 64'd0;
      dvs_q   <= 64'd0;
      cnt_q   <= 7'd0;
    end else begin
      state_q <= state_d;
      opid_q  <= opid_d;
      word_q  <= word_d;
      rsel_q  <= rsel_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      prem_q  <= prem_d;
      dq_q    <= dq_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_fu_div.sv
// tb/tb_fu_div.sv - self-checking bench for fu_div, iterating and early-out instances side by side
module tb_fu_div;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic [15:0] req_opid;
  logic [2:0]  req_funct;
  logic [63:0] req_a, req_b;
  logic        rdy0, rdy1, cl0, cl1;
  logic [15:0] ro0, ro1;
  logic [63:0] rd0, rd1;

  always #5 clk = ~clk;

  fu_div #(.early_out(1'b0)) dut0 (
    .clk(clk), .rst(rst), .flush(flush), .req_opid(req_opid), .req_funct(req_funct),
    .req_a(req_a), .req_b(req_b), .req_ready(rdy0), .resp_opid(ro0), .resp_data(rd0),
    .resp_claim(cl0)
  );

  fu_div #(.early_out(1'b1)) dut1 (
    .clk(clk), .rst(rst), .flush(flush), .req_opid(req_opid), .req_funct(req_funct),
    .req_a(req_a), .req_b(req_b), .req_ready(rdy1), .resp_opid(ro1), .resp_data(rd1),
    .resp_claim(cl1)
  );

  typedef struct {
    logic [15:0] opid;
    logic [63:0] data;
    int          lat0;
    int          lat1;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_div(input logic [2:0] f, input logic [63:0] a, input logic [63:0] b);
    logic [31:0] a32, b32, r32;
    logic [63:0] r64;
    a32 = a[31:0];
    b32 = b[31:0];
    if (f[2]) begin
      if (b32 == 32'd0) r32 = f[1] ? a32 : 32'hFFFF_FFFF;
      else if (!f[0] && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) r32 = f[1] ? 32'd0 : a32;
      else if (f[0]) r32 = f[1] ? (a32 % b32) : (a32 / b32);
      else if (f[1]) r32 = $signed(a32) % $signed(b32);
      else r32 = $signed(a32) / $signed(b32);
      return {{32{r32[31]}}, r32};
    end
    if (b == 64'd0) r64 = f[1] ? a : {64{1'b1}};
    else if (!f[0] && a == 64'h8000_0000_0000_0000 && b == {64{1'b1}}) r64 = f[1] ? 64'd0 : a;
    else if (f[0]) r64 = f[1] ? (a % b) : (a / b);
    else if (f[1]) r64 = $signed(a) % $signed(b);
    else r64 = $signed(a) / $signed(b);
    return r64;
  endfunction

  function automatic bit ref_early(input logic [2:0] f, input logic [63:0] a, input logic [63:0] b);
    if (f[2])
      return (b[31:0] == 32'd0) || (!f[0] && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF);
    return (b == 64'd0) || (!f[0] && a == 64'h8000_0000_0000_0000 && b == {64{1'b1}});
  endfunction

  task automatic set_claim(input int d, input logic v);
    if (d == 0) cl0 = v;
    else cl1 = v;
  endtask

  // Issue one op to both units, then watch each: latency, data, opid, optional hold, claim, release.
  task automatic run_op(input logic [15:0] id, input logic [2:0] f, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] exp_data, input int l0,
                        input int l1, input int hold);
    exp_t        e;
    bit          got;
    int          lat;
    int          phase[2];
    int          held[2];
    logic [63:0] saved[2];
    logic [15:0] o;
    logic [63:0] dd;
    logic        r;
    @(negedge clk);
    chk("ready0_idle", {63'd0, rdy0}, 64'd1);
    chk("ready1_idle", {63'd0, rdy1}, 64'd1);
    req_opid  = id | 16'h8000;
    req_funct = f;
    req_a     = a;
    req_b     = b;
    sb.push_back('{id | 16'h8000, exp_data, l0, l1});
    @(negedge clk);
    req_opid = 16'h0000;
    lat   = 1;
    got   = 1'b0;
    phase = '{0, 0};
    held  = '{0, 0};
    while (lat <= 200 && !(phase[0] == 3 && phase[1] == 3)) begin
      for (int d = 0; d < 2; d++) begin
        o  = (d == 0) ? ro0 : ro1;
        dd = (d == 0) ? rd0 : rd1;
        r  = (d == 0) ? rdy0 : rdy1;
        case (phase[d])
          0: if (o[15]) begin
            if (!got) begin
              e   = sb.pop_front();
              got = 1'b1;
            end
            chk($sformatf("lat%0d_op%h", d, id), lat, (d == 0) ? e.lat0 : e.lat1);
            chk($sformatf("data%0d_op%h", d, id), dd, e.data);
            chk($sformatf("opid%0d_op%h", d, id), {48'd0, o}, {48'd0, e.opid});
            saved[d] = dd;
            if (hold == 0) begin
              set_claim(d, 1'b1);
              phase[d] = 2;
            end else phase[d] = 1;
          end
          1: begin
            chk($sformatf("hold_data%0d", d), dd, saved[d]);
            chk($sformatf("hold_opid%0d", d), {48'd0, o}, {48'd0, e.opid});
            chk($sformatf("hold_ready%0d", d), {63'd0, r}, 64'd0);
            held[d]++;
            if (held[d] >= hold) begin
              set_claim(d, 1'b1);
              phase[d] = 2;
            end
          end
          2: begin
            set_claim(d, 1'b0);
            chk($sformatf("claimed_valid%0d", d), {63'd0, o[15]}, 64'd0);
            chk($sformatf("claimed_ready%0d", d), {63'd0, r}, 64'd1);
            phase[d] = 3;
          end
          default: ;
        endcase
      end
      if (!(phase[0] == 3 && phase[1] == 3)) begin
        @(negedge clk);
        lat++;
      end
    end
    chk($sformatf("complete0_op%h", id), phase[0], 3);
    chk($sformatf("complete1_op%h", id), phase[1], 3);
    cl0 = 1'b0;
    cl1 = 1'b0;
  endtask

  task automatic watch_silent(input string tag, input int cycles);
    bit saw;
    saw = 1'b0;
    repeat (cycles) begin
      @(negedge clk);
      if (ro0[15] || ro1[15]) saw = 1'b1;
    end
    chk(tag, {63'd0, saw}, 64'd0);
  endtask

  // Kill an op in BUSY at T+20 by flush (use_rst=0) or reset (use_rst=1).
  task automatic kill_busy(input logic [15:0] id, input bit use_rst);
    @(negedge clk);
    req_opid  = id | 16'h8000;
    req_funct = 3'b000;
    req_a     = 64'd1000;
    req_b     = 64'd3;
    @(negedge clk);
    req_opid = 16'h0000;
    repeat (19) @(negedge clk);
    if (use_rst) rst = 1'b1;
    else flush = 1'b1;
    @(negedge clk);
    rst   = 1'b0;
    flush = 1'b0;
    chk("kill_valid0", {63'd0, ro0[15]}, 64'd0);
    chk("kill_valid1", {63'd0, ro1[15]}, 64'd0);
    chk("kill_ready0", {63'd0, rdy0}, 64'd1);
    chk("kill_ready1", {63'd0, rdy1}, 64'd1);
    chk("kill_data0", rd0, 64'd0);
    watch_silent("kill_no_resp", 80);
  endtask

  initial begin
    logic [2:0]  f;
    logic [63:0] a, b, x;
    int          n, bsel, wait_cnt;
    rst = 1'b1; flush = 1'b0; cl0 = 1'b0; cl1 = 1'b0;
    req_opid = 16'h0000; req_funct = 3'b000; req_a = 64'd0; req_b = 64'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset_opid0", {48'd0, ro0}, 64'd0);
    chk("reset_opid1", {48'd0, ro1}, 64'd0);
    chk("reset_data0", rd0, 64'd0);
    chk("reset_data1", rd1, 64'd0);
    chk("reset_ready0", {63'd0, rdy0}, 64'd1);
    chk("reset_ready1", {63'd0, rdy1}, 64'd1);

    run_op(16'h0001, 3'b000, 64'd100, 64'd7, 64'd14, 65, 65, 0);
    run_op(16'h0002, 3'b010, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65, 65, 0);
    run_op(16'h0003, 3'b011, 64'd7, 64'd2, 64'd1, 65, 65, 0);
    run_op(16'h0004, 3'b001, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 65, 1, 0);
    run_op(16'h0005, 3'b010, 64'd5, 64'd0, 64'd5, 65, 1, 0);
    run_op(16'h0006, 3'b100, 64'h8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 33, 1, 0);
    run_op(16'h0007, 3'b101, 64'hFFFF_FFFE, 64'd1, 64'hFFFF_FFFF_FFFF_FFFE, 33, 33, 0);
    run_op(16'h0008, 3'b000, -64'sd100, 64'd7, -64'sd14, 65, 65, 0);
    run_op(16'h0009, 3'b010, -64'sd100, 64'd7, -64'sd2, 65, 65, 0);
    run_op(16'h000A, 3'b000, 64'h8000_0000_0000_0000, {64{1'b1}}, 64'h8000_0000_0000_0000, 65, 1, 0);
    run_op(16'h000B, 3'b110, 64'h8000_0000, 64'hFFFF_FFFF, 64'd0, 33, 1, 0);
    run_op(16'h000C, 3'b111, 64'h8000_000A, 64'd0, 64'hFFFF_FFFF_8000_000A, 33, 1, 0);
    run_op(16'h000D, 3'b001, {64{1'b1}}, 64'd3, 64'h5555_5555_5555_5555, 65, 65, 0);
    run_op(16'h000E, 3'b000, -64'sd5, 64'd0, {64{1'b1}}, 65, 1, 0);

    run_op(16'h0010, 3'b100, 64'd1000, 64'd10, 64'd100, 33, 33, 10);

    for (int i = 0; i < 10; i++) begin
      f    = 3'($urandom_range(0, 7));
      a    = {$urandom, $urandom};
      bsel = $urandom_range(0, 4);
      case (bsel)
        0: b = 64'd0;
        1: b = 64'($urandom_range(1, 9));
        2: begin
          b = {64{1'b1}};
          a = f[2] ? 64'h8000_0000 : 64'h8000_0000_0000_0000;
        end
        default: b = {$urandom, $urandom} >> $urandom_range(0, 60);
      endcase
      x = ref_div(f, a, b);
      n = f[2] ? 33 : 65;
      run_op(16'h0100 + 16'(i), f, a, b, x, n, ref_early(f, a, b) ? 1 : n, 0);
    end

    kill_busy(16'h0020, 1'b0);
    kill_busy(16'h0021, 1'b1);

    @(negedge clk);
    req_opid  = 16'h8030;
    req_funct = 3'b101;
    req_a     = 64'd50;
    req_b     = 64'd5;
    @(negedge clk);
    req_opid = 16'h0000;
    wait_cnt = 0;
    while (!(ro0[15] && ro1[15]) && wait_cnt < 100) begin
      @(negedge clk);
      wait_cnt++;
    end
    chk("flushclaim_reached_done", {62'd0, ro0[15], ro1[15]}, 64'd3);
    flush = 1'b1; cl0 = 1'b1; cl1 = 1'b1;
    @(negedge clk);
    flush = 1'b0; cl0 = 1'b0; cl1 = 1'b0;
    chk("flushclaim_valid0", {63'd0, ro0[15]}, 64'd0);
    chk("flushclaim_valid1", {63'd0, ro1[15]}, 64'd0);
    chk("flushclaim_ready0", {63'd0, rdy0}, 64'd1);
    watch_silent("flushclaim_no_resp", 10);

    @(negedge clk);
    flush     = 1'b1;
    req_opid  = 16'h8031;
    req_funct = 3'b000;
    req_a     = 64'd9;
    req_b     = 64'd0;
    @(negedge clk);
    flush    = 1'b0;
    req_opid = 16'h0000;
    chk("flushreq_ready0", {63'd0, rdy0}, 64'd1);
    chk("flushreq_ready1", {63'd0, rdy1}, 64'd1);
    watch_silent("flushreq_no_resp", 80);

    chk("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
